// File: rtl/param_multicycle_cpu_if.sv
// ---------------------------------------------------------------------------
// param_multicycle_cpu_if
//   Host-side bus of the multi-cycle accumulator CPU core: program load,
//   start control, register debug port and architectural status.
//
//   master : host / testbench (drives start, load_*, dbg_sel)
//   slave  : the CPU core     (drives dbg_reg, pc, ir, mbr, mar,
//                              busy, halted, div_err)
//
//   start      single-cycle pulse, begins/resumes execution from IDLE/HALT
//   load_en    memory write strobe, honoured only in IDLE/HALT
//   load_addr  write address for load_en
//   load_data  write data for load_en
//   dbg_sel    register select for dbg_reg
//   dbg_reg    combinational R[dbg_sel]
//   pc/ir/mbr/mar  architectural registers
//   busy       high in any state other than IDLE and HALT
//   halted     high in HALT
//   div_err    sticky divide-by-zero flag
// ---------------------------------------------------------------------------
interface param_multicycle_cpu_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 6,
  parameter int REG_W  = 2
);
  logic              start;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [REG_W-1:0]  dbg_sel;
  logic [DATA_W-1:0] dbg_reg;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mbr;
  logic [ADDR_W-1:0] mar;
  logic              busy;
  logic              halted;
  logic              div_err;

  modport master (
    output start, load_en, load_addr, load_data, dbg_sel,
    input  dbg_reg, pc, ir, mbr, mar, busy, halted, div_err
  );

  modport slave (
    input  start, load_en, load_addr, load_data, dbg_sel,
    output dbg_reg, pc, ir, mbr, mar, busy, halted, div_err
  );
endinterface

// File: rtl/param_multicycle_cpu.sv
// ---------------------------------------------------------------------------
// param_multicycle_cpu
//   Parametrised multi-cycle accumulator-style CPU core with a unified
//   instruction/data memory, NUM_REGS general registers and a
//   FETCH_A / FETCH_I / DECODE / MEM / EXEC state machine.
//
//   Instruction word: op = IR[DATA_W-1 -: 4], rd = IR[ADDR_W+REG_W-1:ADDR_W],
//   a = IR[ADDR_W-1:0].
//   Opcodes: 0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 JMP, 7 JZ,
//   F HALT, everything else NOP.
//
//   Ports:
//     clock    system clock, all logic on posedge
//     reset_n  synchronous active-low reset (memory contents are kept)
//     bus      param_multicycle_cpu_if.slave: load port, start, debug
//              register port and pc/ir/mbr/mar/busy/halted/div_err status
//
//   Build option: define SIGNED_ARITH_EN to make MUL/DIV two's complement
//   (DIV truncates toward zero, MIN / -1 = MIN). Default build is unsigned.
// ---------------------------------------------------------------------------
module param_multicycle_cpu #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 4,
  parameter int START_PC = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  param_multicycle_cpu_if.slave bus
);

  localparam int REG_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_MUL   = 4'h4;
  localparam logic [3:0] OP_DIV   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JZ    = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_A, S_FETCH_I, S_DECODE, S_MEM, S_EXEC, S_HALT
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] pc_reg, mar_reg;
  logic [DATA_W-1:0] ir_reg, mbr_reg;
  logic              div_err_reg;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [3:0]        op;
  logic [REG_W-1:0]  rd;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] alu_res;
  logic              div_zero;

  logic              take_start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              reg_we;

  assign op     = ir_reg[DATA_W-1 -: 4];
  assign rd     = ir_reg[ADDR_W+REG_W-1:ADDR_W];
  assign a      = ir_reg[ADDR_W-1:0];
  assign rd_val = regs[rd];

  // ---------------- state register ----------------
  always_ff @(posedge clock) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // ---------------- next state and strobes ----------------
  always_comb begin
    state_next = state_reg;
    take_start = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = bus.load_addr;
    mem_wdata  = bus.load_data;
    reg_we     = 1'b0;
    case (state_reg)
      S_IDLE, S_HALT: begin
        // A load and a start in the same cycle are both honoured.
        mem_we = bus.load_en;
        if (bus.start) begin
          take_start = 1'b1;
          state_next = S_FETCH_A;
        end
      end
      S_FETCH_A: state_next = S_FETCH_I;
      S_FETCH_I: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_HALT:                 state_next = S_HALT;
          OP_JMP, OP_JZ:           state_next = S_FETCH_A;
          OP_LOAD, OP_STORE, OP_ADD,
          OP_SUB, OP_MUL, OP_DIV:  state_next = S_MEM;
          default:                 state_next = S_FETCH_A;
        endcase
      end
      S_MEM: begin
        if (op == OP_STORE) begin
          mem_we     = 1'b1;
          mem_waddr  = mar_reg;
          mem_wdata  = rd_val;
          state_next = S_FETCH_A;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        reg_we     = 1'b1;
        state_next = S_FETCH_A;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- ALU ----------------
`ifdef SIGNED_ARITH_EN
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  always_comb begin
    div_zero = (mbr_reg == '0);
    alu_res  = mbr_reg;                  // LOAD passes the memory word through
    case (op)
      OP_ADD: alu_res = rd_val + mbr_reg;
      OP_SUB: alu_res = rd_val - mbr_reg;
      // The low DATA_W bits of a product are the same for signed and
      // unsigned operands, so one multiplier serves both builds.
      OP_MUL: alu_res = rd_val * mbr_reg;
      OP_DIV: begin
        if (div_zero) begin
          alu_res = '1;
        end else begin
`ifdef SIGNED_ARITH_EN
          // MIN / -1 overflows; pin it to MIN rather than rely on the
          // division operator's behaviour for an unrepresentable result.
          if (rd_val == SMIN && mbr_reg == '1)
            alu_res = rd_val;
          else
            alu_res = DATA_W'($signed(rd_val) / $signed(mbr_reg));
`else
          alu_res = rd_val / mbr_reg;
`endif
        end
      end
      default: alu_res = mbr_reg;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_reg      <= ADDR_W'(START_PC);
      mar_reg     <= '0;
      ir_reg      <= '0;
      mbr_reg     <= '0;
      div_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_HALT: begin
          if (take_start) div_err_reg <= 1'b0;
        end
        S_FETCH_A: mar_reg <= pc_reg;
        S_FETCH_I: begin
          ir_reg <= mem[mar_reg];
          pc_reg <= pc_reg + ADDR_W'(1);
        end
        S_DECODE: begin
          mar_reg <= a;
          if (op == OP_JMP || (op == OP_JZ && rd_val == '0))
            pc_reg <= a;
        end
        S_MEM: begin
          if (op != OP_STORE) mbr_reg <= mem[mar_reg];
        end
        S_EXEC: begin
          if (op == OP_DIV && div_zero) div_err_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- memory (not reset) ----------------
  // Writes are suppressed while reset is asserted so an aborted STORE or a
  // load during reset never reaches the array.
  always_ff @(posedge clock) begin
    if (reset_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // ---------------- register file ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      logic [DATA_W-1:0] q_reg;
      always_ff @(posedge clock) begin
        if (!reset_n)                            q_reg <= '0;
        else if (reg_we && rd == REG_W'(gi))     q_reg <= alu_res;
      end
      assign regs[gi] = q_reg;
    end
  endgenerate

  // ---------------- outputs ----------------
  assign bus.dbg_reg = regs[bus.dbg_sel];
  assign bus.pc      = pc_reg;
  assign bus.ir      = ir_reg;
  assign bus.mbr     = mbr_reg;
  assign bus.mar     = mar_reg;
  assign bus.busy    = (state_reg != S_IDLE) && (state_reg != S_HALT);
  assign bus.halted  = (state_reg == S_HALT);
  assign bus.div_err = div_err_reg;

endmodule
